// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-status and stall/bubble control bundle between the Y86-64 datapath (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic [3:0] D_icode;
  logic [3:0] D_rA;
  logic [3:0] D_rB;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic       e_cnd;
  logic [3:0] M_icode;
  logic [3:0] m_stat;
  logic [3:0] W_stat;
  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;
  logic       set_cc;
  logic       halted;

  modport master (
    output D_icode, D_rA, D_rB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted
  );

  modport slave (
    input  D_icode, D_rA, D_rB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard control: load-use, mispredict, ret drain and sticky halt.
// Define PIPE_HAZARD_CNT_EN to add saturating stall/bubble event counters.
module pipe_hazard_ctrl #(
  parameter logic [3:0] RSP_ID        = 4'h4,
  parameter logic [3:0] RNONE         = 4'hF,
  parameter int         RET_DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
`ifdef PIPE_HAZARD_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  typedef enum logic [1:0] {RUN, RET_DRAIN, HALTED} state_t;

  localparam logic [1:0] DRAIN_LOAD = 2'(RET_DRAIN_CYC);

  state_t     state;
  logic [1:0] drain_cnt;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic       load_use;
  logic       mispred;
  logic       exc_m;
  logic       exc_w;
  logic       is_ret;

  // The memory-stage icode plays no part in these hazard rules.
  logic unused_m_icode;
  assign unused_m_icode = ^bus.M_icode;

  always_comb begin
    d_srcA = RNONE;
    case (bus.D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srcA = bus.D_rA;
      4'h9, 4'hB:             d_srcA = RSP_ID;
      default:                d_srcA = RNONE;
    endcase
  end

  always_comb begin
    d_srcB = RNONE;
    case (bus.D_icode)
      4'h4, 4'h5, 4'h6:       d_srcB = bus.D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP_ID;
      default:                d_srcB = RNONE;
    endcase
  end

  assign load_use = ((bus.E_icode == 4'h5) || (bus.E_icode == 4'hB)) && (bus.E_dstM != RNONE) &&
                    ((bus.E_dstM == d_srcA) || (bus.E_dstM == d_srcB));
  assign mispred  = (bus.E_icode == 4'h7) && !bus.e_cnd;
  assign exc_m    = (bus.m_stat != 4'h1);
  assign exc_w    = (bus.W_stat != 4'h1);
  assign is_ret   = (bus.D_icode == 4'h9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (exc_w) begin
            state <= HALTED;
          end else if (!load_use && !mispred && is_ret) begin
            state     <= RET_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        RET_DRAIN: begin
          if (exc_w) begin
            state <= HALTED;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1) state <= RUN;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  // Controls are combinational on the current state so hazards are resolved in the same cycle.
  always_comb begin
    bus.F_stall  = 1'b0;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.W_stall  = 1'b0;
    bus.set_cc   = 1'b0;
    bus.halted   = 1'b0;
    if (reset) begin
      bus.F_stall  = 1'b1;
      bus.D_bubble = 1'b1;
      bus.E_bubble = 1'b1;
      bus.M_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            bus.F_stall  = 1'b1;
            bus.D_stall  = 1'b1;
            bus.E_bubble = 1'b1;
          end else if (mispred) begin
            bus.D_bubble = 1'b1;
            bus.E_bubble = 1'b1;
          end else if (is_ret) begin
            bus.F_stall  = 1'b1;
            bus.D_bubble = 1'b1;
          end
        end
        RET_DRAIN: begin
          bus.F_stall  = 1'b1;
          bus.D_bubble = 1'b1;
        end
        HALTED: begin
          bus.F_stall  = 1'b1;
          bus.D_stall  = 1'b1;
          bus.E_bubble = 1'b1;
          bus.M_bubble = 1'b1;
          bus.W_stall  = 1'b1;
          bus.halted   = 1'b1;
        end
        default: ;
      endcase
      bus.M_bubble = bus.M_bubble | exc_m | exc_w;
      bus.set_cc   = (bus.E_icode == 4'h6) && !exc_m && !exc_w && (state != HALTED);
    end
  end

`ifdef PIPE_HAZARD_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else if (state != HALTED) begin
      if (bus.F_stall)                 stall_cnt  <= sat_inc(stall_cnt);
      if (bus.D_bubble || bus.E_bubble) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control vector order is
// {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] ctl;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_HAZARD_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign ctl = {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                bus.M_bubble, bus.W_stall, bus.set_cc, bus.halted};

  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_RST   = 8'b1011_1000;
  localparam logic [7:0] C_LU    = 8'b1101_0000;
  localparam logic [7:0] C_RET   = 8'b1010_0000;
  localparam logic [7:0] C_MISP  = 8'b0011_0000;
  localparam logic [7:0] C_MB    = 8'b0000_1000;
  localparam logic [7:0] C_CC    = 8'b0000_0010;
  localparam logic [7:0] C_HALT  = 8'b1101_1101;
  localparam logic [7:0] C_RETMB = 8'b1010_1000;

  task automatic nops();
    bus.D_icode = 4'h1; bus.D_rA = 4'hF; bus.D_rB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd = 1'b0;
    bus.M_icode = 4'h1; bus.m_stat = 4'h1; bus.W_stat = 4'h1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; nops(); bus.E_icode = 4'h6; #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_forced: got %b want %b", ctl, C_RST); end
    tick(); tick();
    reset = 1'b0; nops(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL reset_release: got %b want %b", ctl, C_NONE); end
    tick();
  endtask

  task automatic test_load_use();
    nops(); bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.D_icode = 4'h6; bus.D_rA = 4'h3; bus.D_rB = 4'h7; #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rA: got %b want %b", ctl, C_LU); end
    tick();
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL load_use_after: got %b want %b", ctl, C_NONE); end
    tick();
    nops(); bus.E_icode = 4'h5; bus.E_dstM = 4'h7; bus.D_icode = 4'h5; bus.D_rA = 4'h2; bus.D_rB = 4'h7; #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rB: got %b want %b", ctl, C_LU); end
    tick();
    nops(); bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.D_icode = 4'h3; bus.D_rA = 4'h3; bus.D_rB = 4'h3; #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL load_use_irmovq: got %b want %b", ctl, C_NONE); end
    tick();
    nops(); bus.E_icode = 4'h5; bus.E_dstM = 4'hF; bus.D_icode = 4'h2; bus.D_rA = 4'hF; #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL load_use_rnone: got %b want %b", ctl, C_NONE); end
    tick();
    nops(); bus.E_icode = 4'h6; #1;
    checks++; if (ctl !== C_CC) begin errors++; $display("FAIL set_cc_opq: got %b want %b", ctl, C_CC); end
    tick();
  endtask

  task automatic test_ret_drain();
    nops(); bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_cyc0: got %b want %b", ctl, C_RET); end
    tick();
    nops(); #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_cyc1: got %b want %b", ctl, C_RET); end
    tick(); #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_cyc2: got %b want %b", ctl, C_RET); end
    tick(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL ret_cyc3: got %b want %b", ctl, C_NONE); end
    tick();
  endtask

  task automatic test_ret_held_by_load_use();
    nops(); bus.E_icode = 4'hB; bus.E_dstM = 4'h4; bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL ret_held: got %b want %b", ctl, C_LU); end
    tick();
    nops(); bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_after_hold: got %b want %b", ctl, C_RET); end
    tick();
    nops(); #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_hold_drain1: got %b want %b", ctl, C_RET); end
    tick(); #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_hold_drain2: got %b want %b", ctl, C_RET); end
    tick(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL ret_hold_done: got %b want %b", ctl, C_NONE); end
    tick();
  endtask

  task automatic test_mispred();
    nops(); bus.E_icode = 4'h7; bus.e_cnd = 1'b0; bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== C_MISP) begin errors++; $display("FAIL mispred_ret: got %b want %b", ctl, C_MISP); end
    tick();
    nops(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mispred_no_drain: got %b want %b", ctl, C_NONE); end
    tick();
    nops(); bus.E_icode = 4'h7; bus.e_cnd = 1'b1; #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL jxx_taken: got %b want %b", ctl, C_NONE); end
    tick();
  endtask

  task automatic test_exception_halt();
    nops(); bus.m_stat = 4'h3; bus.E_icode = 4'h6; #1;
    checks++; if (ctl !== C_MB) begin errors++; $display("FAIL exc_m: got %b want %b", ctl, C_MB); end
    tick();
    nops(); bus.W_stat = 4'h3; #1;
    checks++; if (ctl !== C_MB) begin errors++; $display("FAIL exc_w_run: got %b want %b", ctl, C_MB); end
    tick();
    for (int i = 0; i < 10; i++) begin
      nops(); bus.E_icode = 4'h6; bus.D_icode = 4'h9; #1;
      checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL halted_cyc%0d: got %b want %b", i, ctl, C_HALT); end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    reset = 1'b1; nops(); #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_in_halt: got %b want %b", ctl, C_RST); end
    tick();
    reset = 1'b0; nops(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL halt_cleared: got %b want %b", ctl, C_NONE); end
    tick();
    bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL ret_before_rst: got %b want %b", ctl, C_RET); end
    tick();
    nops(); reset = 1'b1; #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_in_drain: got %b want %b", ctl, C_RST); end
    tick();
    reset = 1'b0; #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL drain_abort0: got %b want %b", ctl, C_NONE); end
    tick(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL drain_abort1: got %b want %b", ctl, C_NONE); end
    tick();
  endtask

  task automatic test_exc_in_drain();
    nops(); bus.D_icode = 4'h9; #1;
    checks++; if (ctl !== C_RET) begin errors++; $display("FAIL drain_exc_ret: got %b want %b", ctl, C_RET); end
    tick();
    nops(); bus.W_stat = 4'h2; #1;
    checks++; if (ctl !== C_RETMB) begin errors++; $display("FAIL drain_exc_w: got %b want %b", ctl, C_RETMB); end
    tick();
    nops(); #1;
    checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL drain_to_halt: got %b want %b", ctl, C_HALT); end
    tick();
    reset = 1'b1; tick(); reset = 1'b0; nops(); #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL drain_exc_clear: got %b want %b", ctl, C_NONE); end
    tick();
  endtask

`ifdef PIPE_HAZARD_CNT_EN
  task automatic test_counters();
    reset = 1'b1; nops(); tick();
    reset = 1'b0; #1;
    checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      errors++; $display("FAIL cnt_reset: got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    end
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.D_icode = 4'h6; bus.D_rA = 4'h3;
    tick(); tick();
    nops(); bus.D_icode = 4'h9; tick();
    nops(); tick(); tick(); #1;
    checks++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd5) begin
      errors++; $display("FAIL cnt_values: got %0d/%0d want 5/5", stall_cnt, bubble_cnt);
    end
    bus.W_stat = 4'h3; tick(); nops(); tick(); tick(); #1;
    checks++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd5) begin
      errors++; $display("FAIL cnt_halted: got %0d/%0d want 5/5", stall_cnt, bubble_cnt);
    end
    reset = 1'b1; tick(); reset = 1'b0; nops(); tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    nops();
    tick();
    test_reset();
    test_load_use();
    test_ret_drain();
    test_ret_held_by_load_use();
    test_mispred();
    test_exception_halt();
    test_reset_abort();
    test_exc_in_drain();
`ifdef PIPE_HAZARD_CNT_EN
    test_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
